eq_out_stage: RTL and testbench
===============================

EQ_OUT_STAGE -- requirements
Module: eq_out_stage

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, giving the signed sample width.
REQ-002 The module SHALL have parameter DECIM, default 2, giving the decimation ratio (legal 1..16).
REQ-003 The module SHALL have parameter DEPTH, default 4, giving the FIFO depth (power of two, at least 2).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port yn, input, DATA_W bits, signed: the equalizer FIR filter output sample.
REQ-007 The module SHALL have port in_valid, input, 1 bit: yn is a new filter sample this cycle.
REQ-008 The module SHALL have port gain_sh, input, 2 bits: arithmetic left-shift gain of 0..3, sampled along with the sample it scales.
REQ-009 The module SHALL have port out_data, output, DATA_W bits, signed: the FIFO head.
REQ-010 The module SHALL have port out_valid, output, 1 bit: the FIFO is non-empty.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-012 The module SHALL have port fill, output, clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-013 The module SHALL have port ovf, output, 1 bit: sticky flag set when a kept sample was dropped.
REQ-014 The module SHALL have port ovf_clr, input, 1 bit: clears ovf.

Function
REQ-015 Phase counter: increments modulo DECIM on each in_valid; a sample is kept only when phase==0 at its arrival.
REQ-016 Scale stage: a kept sample is registered as (yn <<< gain_sh), computed at DATA_W+3 bits, and the stage valid flag is set for 1 cycle.
REQ-017 Width reduction: the DATA_W+3-bit result is reduced to DATA_W per REQ-029/030.
REQ-018 Write path: the scale-stage result is written to the FIFO in the cycle its valid flag is high.
REQ-019 Latency: in_valid in cycle N with an empty FIFO gives out_valid=1 and out_data=result in cycle N+2.
REQ-020 Pop: a pop occurs when out_valid and out_ready are both high; the head advances at that edge.
REQ-021 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 FIFO full with a write and no pop: the write is dropped, ovf is set, and fill stays at DEPTH.
REQ-023 FIFO full with a write and a pop in the same cycle: the write is accepted and fill stays at DEPTH.
REQ-024 FIFO empty: out_valid=0; out_ready is ignored; fill is never negative.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 ovf_clr and a new overflow in the same cycle: the set wins, so ovf=1.
REQ-027 Samples SHALL leave the FIFO in arrival order; there is no reordering and no duplication.

Reset
REQ-028 rst=1 at a clock edge SHALL clear: phase=0, scale valid=0, pointers=0, fill=0, ovf=0, out_valid=0, out_data=0. A sample in flight is discarded, rst overrides in_valid and out_ready in the same cycle, and the first in_valid after reset is kept.

Configuration
REQ-029 With macro EQ_OUT_SAT_EN defined, results above 2^(DATA_W-1)-1 SHALL saturate to 0x7FFF and results below -2^(DATA_W-1) to 0x8000 (DATA_W=16).
REQ-030 With EQ_OUT_SAT_EN undefined, the result SHALL be truncated to its low DATA_W bits (two's-complement wrap).

Verification
REQ-031 Scenario: DECIM=1, gain_sh=2, yn=0x1000 -> out_data=0x4000 exactly 2 cycles after in_valid.
REQ-032 Scenario: DECIM=1, gain_sh=2, yn=0x2000 and then yn=0xD000 -> 0x7FFF and 0x8000 with EQ_OUT_SAT_EN; 0x8000 and 0x4000 without it.
REQ-033 Scenario: DECIM=2, gain_sh=0, in_valid on yn=1,2,3,4,5 -> outputs 1,3,5 in order.
REQ-034 Scenario: DECIM=1, out_ready=0, 6 consecutive samples 1..6 -> fill=4, FIFO holds 1..4, ovf=1; then ovf_clr -> ovf=0; then out_ready=1 -> outputs 1,2,3,4 and fill=0.
REQ-035 Scenario: FIFO full, in_valid and out_ready high together -> head popped, new sample stored, fill=4, ovf unchanged.
REQ-036 Scenario: rst pulse with fill=3 and a sample in the scale stage -> next cycle fill=0, out_valid=0, ovf=0; the next in_valid sample appears 2 cycles later.

Source files
------------

// File: rtl/eq_out_stage.sv
// eq_out_stage: output stage of the equalizer.
// The FIR output is decimated by DECIM, scaled by an arithmetic left shift of
// 0..3, reduced back to DATA_W bits and queued in a DEPTH-entry FIFO that the
// consumer drains with a valid/ready handshake.
//
// Optional feature macro: EQ_OUT_SAT_EN
//   defined   -> the scaled result saturates to the DATA_W signed range
//   undefined -> the scaled result wraps (keeps its low DATA_W bits)
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   yn         signed filter sample
//   in_valid   yn is a new sample this cycle
//   gain_sh    left-shift gain, sampled with the sample it scales
//   out_data   FIFO head (0 while the FIFO is empty)
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts out_data
//   fill       FIFO occupancy, 0..DEPTH
//   ovf        sticky: a kept sample was dropped because the FIFO was full
//   ovf_clr    clears ovf (a simultaneous new overflow wins)
module eq_out_stage #(
    parameter int DATA_W = 16,
    parameter int DECIM  = 2,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [DATA_W-1:0]   yn,
    input  logic                       in_valid,
    input  logic [1:0]                 gain_sh,
    output logic signed [DATA_W-1:0]   out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       ovf,
    input  logic                       ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int EW = DATA_W + 3;

    logic [PW-1:0]     phase_q, phase_d;
    logic [DATA_W-1:0] scl_data_q, scl_data_d;
    logic              scl_valid_q, scl_valid_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              keep;
    logic [EW-1:0]     ext;
    logic [EW-1:0]     shifted;
    logic [DATA_W-1:0] reduced;
    logic              pop;
    logic              full;
    logic              wr_en;
    logic              drop;

    // Decimation and scaling
    always_comb begin
        keep    = in_valid && (phase_q == '0);
        phase_d = phase_q;
        if (in_valid) begin
            phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
        end

        ext     = {{3{yn[DATA_W-1]}}, yn};
        shifted = ext << gain_sh;
`ifdef EQ_OUT_SAT_EN
        // In range only if the 4 bits from the new sign bit upward all agree.
        if ((&shifted[EW-1:DATA_W-1]) || !(|shifted[EW-1:DATA_W-1])) begin
            reduced = shifted[DATA_W-1:0];
        end else if (shifted[EW-1]) begin
            reduced = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            reduced = {1'b0, {(DATA_W-1){1'b1}}};
        end
`else
        reduced = shifted[DATA_W-1:0];
`endif

        scl_valid_d = keep;
        scl_data_d  = keep ? reduced : scl_data_q;
    end

    // FIFO control: a pop in the same cycle frees the slot for a write into a full FIFO.
    always_comb begin
        pop   = (fill_q != '0) && out_ready;
        full  = (fill_q == FW'(DEPTH));
        wr_en = scl_valid_q && (!full || pop);
        drop  = scl_valid_q && full && !pop;

        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(wr_en);

        fill_d = fill_q;
        case ({wr_en, pop})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase

        ovf_d = drop || (ovf_q && !ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= '0;
            scl_data_q  <= '0;
            scl_valid_q <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            scl_data_q  <= scl_data_d;
            scl_valid_q <= scl_valid_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage is not reset; out_data is forced to 0 while empty instead.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_ptr_q] <= scl_data_q;
        end
    end

    assign out_valid = (fill_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fill      = fill_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_eq_out_stage.sv
module tb_eq_out_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [1:0]  gain_sh = 2'd0;
    logic [15:0] yn = 16'd0;

    logic [15:0] o_data [2];
    logic        o_valid [2];
    logic [2:0]  o_fill [2];
    logic        o_ovf [2];

    eq_out_stage #(.DATA_W(16), .DECIM(1), .DEPTH(4)) u_d1 (
        .clk(clk), .rst(rst), .yn(yn), .in_valid(in_valid), .gain_sh(gain_sh),
        .out_data(o_data[0]), .out_valid(o_valid[0]), .out_ready(out_ready),
        .fill(o_fill[0]), .ovf(o_ovf[0]), .ovf_clr(ovf_clr)
    );

    eq_out_stage #(.DATA_W(16), .DECIM(2), .DEPTH(4)) u_d2 (
        .clk(clk), .rst(rst), .yn(yn), .in_valid(in_valid), .gain_sh(gain_sh),
        .out_data(o_data[1]), .out_valid(o_valid[1]), .out_ready(out_ready),
        .fill(o_fill[1]), .ovf(o_ovf[1]), .ovf_clr(ovf_clr)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Reference model: integer arithmetic on the sample value, queue for the FIFO.
    localparam int DEPTH = 4;
    int          dec [2] = '{1, 2};
    logic [15:0] mq [2][$];
    bit          m_pv [2];
    logic [15:0] m_pd [2];
    int          m_cnt [2];
    bit          m_ovf [2];

    function automatic logic [15:0] scale(input logic [15:0] x, input logic [1:0] g);
        int v;
        v = int'($signed(x)) * (1 << g);
`ifdef EQ_OUT_SAT_EN
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
`endif
        return v[15:0];
    endfunction

    always @(posedge clk) begin : p_model
        bit pop;
        bit drop;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mq[i].delete();
                m_pv[i]  = 1'b0;
                m_cnt[i] = 0;
                m_ovf[i] = 1'b0;
            end else begin
                pop = (mq[i].size() > 0) && out_ready;
                if (pop) void'(mq[i].pop_front());
                drop = 1'b0;
                if (m_pv[i]) begin
                    if (mq[i].size() == DEPTH) drop = 1'b1;
                    else mq[i].push_back(m_pd[i]);
                end
                if (drop) m_ovf[i] = 1'b1;
                else if (ovf_clr) m_ovf[i] = 1'b0;
                m_pv[i] = in_valid && (m_cnt[i] == 0);
                m_pd[i] = scale(yn, gain_sh);
                if (in_valid) m_cnt[i] = (m_cnt[i] + 1) % dec[i];
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("m_valid%0d", i), o_valid[i], mq[i].size() > 0);
                chk($sformatf("m_fill%0d", i), o_fill[i], mq[i].size());
                chk($sformatf("m_ovf%0d", i), o_ovf[i], m_ovf[i]);
                if (mq[i].size() > 0) chk($sformatf("m_data%0d", i), o_data[i], mq[i][0]);
            end
        end
    end

    logic [15:0] exp_a, exp_b;

    initial begin
`ifdef EQ_OUT_SAT_EN
        exp_a = 16'h7FFF;
        exp_b = 16'h8000;
`else
        exp_a = 16'h8000;
        exp_b = 16'h4000;
`endif
        chk("pin_scale_1000", scale(yn + 16'h1000, 2'd2), 16'h4000);
        chk("pin_scale_2000", scale(yn + 16'h2000, 2'd2), exp_a);
        chk("pin_scale_d000", scale(yn + 16'hD000, 2'd2), exp_b);

        step();
        step();
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("rst_valid", o_valid[0], 0);
        chk("rst_fill", o_fill[0], 0);
        chk("rst_ovf", o_ovf[0], 0);
        chk("rst_data", o_data[0], 0);

        // Two-cycle latency, gain 2
        gain_sh = 2'd2; yn = 16'h1000; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lat1_valid", o_valid[0], 0);
        step();
        chk("lat2_valid", o_valid[0], 1);
        chk("lat2_data", o_data[0], 16'h4000);
        step();
        chk("pop_fill", o_fill[0], 0);

        // Saturation / wrap
        reset_pulse();
        out_ready = 1'b0;
        yn = 16'h2000; in_valid = 1'b1;
        step();
        yn = 16'hD000;
        step();
        in_valid = 1'b0;
        step();
        chk("sat_fill", o_fill[0], 2);
        chk("sat_hi", o_data[0], exp_a);
        out_ready = 1'b1;
        step();
        chk("sat_lo", o_data[0], exp_b);
        step();
        chk("sat_drain", o_fill[0], 0);

        // Decimation by 2
        reset_pulse();
        gain_sh = 2'd0; out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            yn = 16'(k); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        chk("dec_fill", o_fill[1], 3);
        chk("dec_out1", o_data[1], 1);
        out_ready = 1'b1;
        step();
        chk("dec_out3", o_data[1], 3);
        step();
        chk("dec_out5", o_data[1], 5);
        step();
        chk("dec_empty", o_fill[1], 0);

        // Overflow, clear, drain
        reset_pulse();
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            yn = 16'(k); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        chk("ovf_fill", o_fill[0], 4);
        chk("ovf_set", o_ovf[0], 1);
        chk("ovf_head", o_data[0], 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", o_ovf[0], 0);
        out_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            step();
            chk("ovf_drain", o_data[0], 32'(k));
        end
        step();
        chk("ovf_empty_fill", o_fill[0], 0);
        chk("ovf_empty_valid", o_valid[0], 0);

        // Full FIFO, write and pop on the same edge
        reset_pulse();
        out_ready = 1'b0;
        for (int k = 10; k <= 13; k++) begin
            yn = 16'(k); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        chk("full_fill", o_fill[0], 4);
        chk("full_ovf", o_ovf[0], 0);
        yn = 16'd14; in_valid = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("wp_fill", o_fill[0], 4);
        chk("wp_head", o_data[0], 11);
        chk("wp_ovf", o_ovf[0], 0);

        // Overflow set wins over a simultaneous clear
        yn = 16'd20; in_valid = 1'b1;
        step();
        in_valid = 1'b0; ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("setwin_ovf", o_ovf[0], 1);
        chk("setwin_fill", o_fill[0], 4);
        out_ready = 1'b1;
        for (int k = 12; k <= 14; k++) begin
            step();
            chk("wp_order", o_data[0], 32'(k));
        end
        step();
        chk("wp_empty", o_fill[0], 0);

        // Reset with data queued and a sample in flight
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            yn = 16'(k); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        chk("prerst_fill", o_fill[0], 3);
        chk("prerst_ovf", o_ovf[0], 1);
        yn = 16'd7; in_valid = 1'b1;
        step();
        rst = 1'b1; yn = 16'd8; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("rst2_fill", o_fill[0], 0);
        chk("rst2_valid", o_valid[0], 0);
        chk("rst2_ovf", o_ovf[0], 0);
        step();
        chk("rst2_flush", o_fill[0], 0);
        yn = 16'd9; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("rst2_lat1", o_valid[0], 0);
        step();
        chk("rst2_lat2_valid", o_valid[0], 1);
        chk("rst2_lat2_data", o_data[0], 9);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
